mem_port_arbiter: RTL

// - Shares one unified instruction/data memory port between instruction fetch (IF) and load/store (LS).
// - Sits between the fetch/LS stages and the SRAM. Sequences every access with a req/valid handshake.
// - Drives stall_o to freeze the PC and datapath until every pending access completes.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_watchdog.sv | 33 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    // Arbiter FSM encoding: idle, instruction fetch owns the port, load/store owns the port
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_LS   = 2'd2
    } arb_state_e;

    localparam int          REG_W           = 32;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [3:0]  WE_DISABLE      = 4'b0000;
    localparam int          TIMEOUT_DEFAULT = 16;

    // Counter width needed to count 0..timeout-1
    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/load-store/memory signal bundle for the arbiter
// Ports: IF request/response, LS request/response, SRAM request/response, stall_o, err_o.
// slave modport is the arbiter's view; master modport is the environment's view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic             if_req_i;
    logic [REG_W-1:0] if_addr_i;
    logic [REG_W-1:0] if_rdata_o;
    logic             if_valid_o;
    logic             ls_req_i;
    logic             ls_we_i;
    logic [3:0]       ls_sel_i;
    logic [REG_W-1:0] ls_addr_i;
    logic [REG_W-1:0] ls_wdata_i;
    logic [REG_W-1:0] ls_rdata_o;
    logic             ls_valid_o;
    logic             mem_en_o;
    logic [3:0]       mem_we_o;
    logic [REG_W-1:0] mem_addr_o;
    logic [REG_W-1:0] mem_wdata_o;
    logic [REG_W-1:0] mem_rdata_i;
    logic             mem_ready_i;
    logic             stall_o;
    logic             err_o;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
               mem_rdata_i, mem_ready_i,
        output if_rdata_o, if_valid_o, ls_rdata_o, ls_valid_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
               mem_rdata_i, mem_ready_i,
        input  if_rdata_o, if_valid_o, ls_rdata_o, ls_valid_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - busy-cycle watchdog counter for the memory port arbiter
// Ports: clk, rst (async high), clr_i (restart count), en_i (busy cycle without ready),
//        expire_o (this enabled cycle is the TIMEOUT-th without ready).
module mem_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = wd_width(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Clear wins: an expiry always coincides with re-arbitration, which clears.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + CW'(1);
    end

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM port between instruction fetch and load/store
// Ports: clk, rst (async high), bus (mem_port_arbiter_if.slave: IF req/addr/rdata/valid,
//        LS req/we/sel/addr/wdata/rdata/valid, mem en/we/addr/wdata/rdata/ready, stall_o, err_o).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    arb_state_e       state_q, state_d;
    logic             mem_en_q, mem_en_d;
    logic [3:0]       mem_we_q, mem_we_d;
    logic [REG_W-1:0] mem_addr_q, mem_addr_d;
    logic [REG_W-1:0] mem_wdata_q, mem_wdata_d;
    logic             store_q, store_d;
    logic [REG_W-1:0] if_rdata_q, if_rdata_d;
    logic [REG_W-1:0] ls_rdata_q, ls_rdata_d;
    logic             if_valid_q, if_valid_d;
    logic             ls_valid_q, ls_valid_d;
    logic             err_q, err_d;

    logic busy, ready, expire, done, arb;
    logic if_cand, ls_cand, grant_ls, grant_if;

    assign busy  = (state_q != ARB_IDLE);
    assign ready = busy & bus.mem_ready_i;
    assign done  = ready | expire;
    assign arb   = ~busy | done;

    // A requester is skipped while its completion is in flight (done this cycle) or
    // being reported (valid pulse), so a req not yet dropped is never granted twice.
    // Skipping the finishing LS is also what hands the port to a waiting IF.
    assign ls_cand  = bus.ls_req_i & ~ls_valid_q & ~(done & (state_q == ARB_LS));
    assign if_cand  = bus.if_req_i & ~if_valid_q & ~(done & (state_q == ARB_IF));
    assign grant_ls = arb & ls_cand;
    assign grant_if = arb & ~ls_cand & if_cand;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (arb),
        .en_i     (busy & ~bus.mem_ready_i),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= WE_DISABLE;
            mem_addr_q  <= ZERO_WORD;
            mem_wdata_q <= ZERO_WORD;
            store_q     <= 1'b0;
            if_rdata_q  <= ZERO_WORD;
            ls_rdata_q  <= ZERO_WORD;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            store_q     <= store_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        store_d     = store_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        err_d       = err_q;

        // Completion (real or watchdog): report to the owner; a timeout returns zero data.
        if (done) begin
            if (state_q == ARB_IF) begin
                if_valid_d = 1'b1;
                if_rdata_d = ready ? bus.mem_rdata_i : ZERO_WORD;
            end else begin
                ls_valid_d = 1'b1;
                if (!store_q) ls_rdata_d = ready ? bus.mem_rdata_i : ZERO_WORD;
            end
            if (expire) err_d = 1'b1;
        end

        if (arb) begin
            if (grant_ls) begin
                state_d     = ARB_LS;
                mem_en_d    = 1'b1;
                mem_we_d    = bus.ls_we_i ? bus.ls_sel_i : WE_DISABLE;
                mem_addr_d  = bus.ls_addr_i;
                mem_wdata_d = bus.ls_wdata_i;
                store_d     = bus.ls_we_i;
            end else if (grant_if) begin
                state_d     = ARB_IF;
                mem_en_d    = 1'b1;
                mem_we_d    = WE_DISABLE;
                mem_addr_d  = bus.if_addr_i;
                mem_wdata_d = ZERO_WORD;
                store_d     = 1'b0;
            end else begin
                state_d  = ARB_IDLE;
                mem_en_d = 1'b0;
            end
        end
    end

    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.ls_rdata_o  = ls_rdata_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.ls_valid_o  = ls_valid_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_valid_q) | (bus.ls_req_i & ~ls_valid_q);
endmodule
